mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-stage controller of the pipelined core; it consumes the EX/MEM pipeline register outputs.
- Performs the data-memory load or store over a req/ack bus with variable latency, and stalls upstream stages while the access is outstanding.
- Owns the MEM/WB pipeline register that feeds writeback.
- Non-memory instructions pass through with one register stage.

Parameters:
- WIDTH, 32, datapath and address width.
- TIMEOUT, 16, maximum ACCESS cycles to wait for mem_ack before aborting (valid range 1..255).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ALURESULT  input  WIDTH  EX/MEM ALU result; the memory address for loads and stores.
- DATA2  input  WIDTH  EX/MEM store data.
- INST  input  32  EX/MEM instruction word.
- RD  input  4  EX/MEM destination register.
- RWRITE  input  1  EX/MEM register-write enable.
- WE  input  1  store request.
- SELECTMEM  input  1  load request; writeback takes memory data.
- mem_req  output  1  memory request, held until ack or timeout.
- mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
- mem_addr  output  WIDTH  captured ALURESULT.
- mem_wdata  output  WIDTH  captured DATA2.
- mem_rdata  input  WIDTH  load data; sampled only on the mem_ack cycle.
- mem_ack  input  1  one-cycle completion pulse.
- stall  output  1  combinational; upstream must hold EX/MEM while it is 1.
- WB_DATA  output  WIDTH  MEM/WB writeback value.
- WB_RD  output  4  MEM/WB destination register.
- WB_RWRITE  output  1  MEM/WB register-write enable.
- WB_INST  output  32  MEM/WB instruction word.
- err  output  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timeout counter=0, captured registers=0, every registered output=0, err=0. mem_req drops immediately, including mid-ACCESS.
- Access condition: acc = WE | SELECTMEM. If both are 1, treat as a store (mem_we=1, WB_DATA=ALURESULT).
- FSM states: IDLE, ACCESS, DONE.
- IDLE, acc=0:
  - stall=0.
  - Next edge: WB_DATA=ALURESULT, WB_RD=RD, WB_RWRITE=RWRITE, WB_INST=INST.
  - Latency is 1 cycle.
- IDLE, acc=1:
  - stall=1.
  - Next edge: capture address, data, we, rd, rwrite, inst; counter=0; go to ACCESS.
  - MEM/WB loads a bubble (WB_RWRITE=0, WB_INST=0, WB_DATA=0, WB_RD=0).
- ACCESS:
  - mem_req=1, stall=1; mem_addr, mem_wdata, mem_we come from captured registers and are stable for the whole request.
  - MEM/WB loads a bubble each cycle.
  - mem_ack=1: latch result (mem_rdata for a load, captured address for a store); go to DONE.
  - mem_ack=0: counter+1. When counter reaches TIMEOUT-1 without ack: mem_req drops next cycle, err<=1, result=0, captured rwrite forced to 0, go to DONE.
  - mem_ack and timeout on the same cycle: ack wins, no error.
- DONE:
  - stall=0, mem_req=0.
  - Next edge: MEM/WB loads the captured rd, inst, rwrite and the result; go to IDLE.
  - EX/MEM advances on the same edge; the next instruction is evaluated in IDLE on the following cycle.
- Occupancy: a memory op with ack in the first ACCESS cycle has 2 stall cycles and 3 cycles total. Each additional wait cycle adds one stall cycle.
- mem_ack outside ACCESS is ignored.
- mem_rdata is ignored unless mem_ack=1 in ACCESS.
- err clears only on reset.
- Bubble from upstream (all inputs 0) is a non-access op and writes a zero bubble to MEM/WB.
- Width rules: no sign or size extension; the full WIDTH word is transferred.

Test Plan:
- ALU op: reset release, ALURESULT=0x0000_1234, RD=3, RWRITE=1, WE=SELECTMEM=0 -> next edge WB_DATA=0x1234, WB_RD=3, WB_RWRITE=1; stall never asserted; mem_req=0.
- Load, ack after 2 cycles: SELECTMEM=1, ALURESULT=0x100, RD=5, mem_rdata=0xDEADBEEF -> stall high 3 cycles; mem_req high 2 cycles with mem_addr=0x100, mem_we=0; WB bubbles during stall; then WB_DATA=0xDEADBEEF, WB_RD=5, WB_RWRITE=1.
- Store: WE=1, ALURESULT=0x200, DATA2=0xA5A5_A5A5, ack in first ACCESS cycle -> mem_we=1, mem_wdata=0xA5A5A5A5; stall 2 cycles; WB_DATA=0x200.
- Timeout: TIMEOUT=4, load with no ack -> mem_req high exactly 4 cycles then low; err=1 and stays 1; WB_RWRITE=0, WB_DATA=0; the next ALU op passes normally.
- Reset mid-access: assert reset low during ACCESS -> mem_req, stall, err and all WB outputs are 0 immediately; after release the FSM is in IDLE; a stray mem_ack is ignored.
- Back-to-back: load followed by ALU op with RD=7 -> the ALU result reaches MEM/WB exactly one edge after the load's writeback; no duplicate writeback of the load.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-stage controller: performs a data-memory load or store over a
// variable-latency req/ack bus.
//
// - Upstream stages are stalled while the access is outstanding.
// - Owns the MEM/WB pipeline register.
// - Non-memory instructions pass through with one register stage.
// - An access that sees no ack within TIMEOUT request cycles is abandoned.
//   The instruction then retires with a zero result, its register write is
//   suppressed, and a sticky error flag is raised.
module mem_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16    // request cycles before abort, 1..255
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    // EX/MEM pipeline register
    input  logic [WIDTH-1:0] ALURESULT,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [31:0]      INST,
    input  logic [3:0]       RD,
    input  logic             RWRITE,
    input  logic             WE,
    input  logic             SELECTMEM,
    // data-memory bus
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    // pipeline control
    output logic             stall,
    // MEM/WB pipeline register
    output logic [WIDTH-1:0] WB_DATA,
    output logic [3:0]       WB_RD,
    output logic             WB_RWRITE,
    output logic [31:0]      WB_INST,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter value seen in the last request cycle before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q,     state_d;
    logic [7:0]       count_q,     count_d;
    logic [WIDTH-1:0] addr_q,      addr_d;
    logic [WIDTH-1:0] wdata_q,     wdata_d;
    logic             we_q,        we_d;
    logic [3:0]       rd_q,        rd_d;
    logic             rwrite_q,    rwrite_d;
    logic [31:0]      inst_q,      inst_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             err_q,       err_d;
    logic [WIDTH-1:0] wb_data_q,   wb_data_d;
    logic [3:0]       wb_rd_q,     wb_rd_d;
    logic             wb_rwrite_q, wb_rwrite_d;
    logic [31:0]      wb_inst_q,   wb_inst_d;

    logic acc;

    // A store takes precedence when both request bits are set.
    assign acc = WE | SELECTMEM;

    // Next-state, capture and MEM/WB update logic.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_d        = rd_q;
        rwrite_d    = rwrite_q;
        inst_d      = inst_q;
        result_d    = result_q;
        err_d       = err_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_rwrite_d = wb_rwrite_q;
        wb_inst_d   = wb_inst_q;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    addr_d      = ALURESULT;
                    wdata_d     = DATA2;
                    we_d        = WE;
                    rd_d        = RD;
                    rwrite_d    = RWRITE;
                    inst_d      = INST;
                    count_d     = 8'd0;
                    state_d     = ACCESS;
                    wb_data_d   = '0;
                    wb_rd_d     = '0;
                    wb_rwrite_d = 1'b0;
                    wb_inst_d   = '0;
                end else begin
                    wb_data_d   = ALURESULT;
                    wb_rd_d     = RD;
                    wb_rwrite_d = RWRITE;
                    wb_inst_d   = INST;
                end
            end

            ACCESS: begin
                wb_data_d   = '0;
                wb_rd_d     = '0;
                wb_rwrite_d = 1'b0;
                wb_inst_d   = '0;
                if (mem_ack) begin
                    // An ack in the final allowed cycle still completes cleanly.
                    result_d = we_q ? addr_q : mem_rdata;
                    state_d  = DONE;
                end else if (count_q == TIMEOUT_LAST) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    rwrite_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end

            DONE: begin
                wb_data_d   = result_q;
                wb_rd_d     = rd_q;
                wb_rwrite_d = rwrite_q;
                wb_inst_d   = inst_q;
                state_d     = IDLE;
            end

            default: begin
                wb_data_d   = '0;
                wb_rd_d     = '0;
                wb_rwrite_d = 1'b0;
                wb_inst_d   = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, captured operands and MEM/WB register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            rwrite_q    <= 1'b0;
            inst_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rwrite_q <= 1'b0;
            wb_inst_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its _d
            // value from before the edge, whatever the statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            rwrite_q    <= rwrite_d;
            inst_q      <= inst_d;
            result_q    <= result_d;
            err_q       <= err_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rwrite_q <= wb_rwrite_d;
            wb_inst_q   <= wb_inst_d;
        end
    end

    // The request follows the state register, so reset removes it at once.
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // The stall is gated by reset so that upstream is released immediately,
    // even while EX/MEM still presents a memory op.
    assign stall = reset & (((state_q == IDLE) & acc) | (state_q == ACCESS));

    assign WB_DATA   = wb_data_q;
    assign WB_RD     = wb_rd_q;
    assign WB_RWRITE = wb_rwrite_q;
    assign WB_INST   = wb_inst_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=4).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_mem_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] alu_result;
    logic [W-1:0] data2;
    logic [31:0]  inst;
    logic [3:0]   rd;
    logic         rwrite;
    logic         we;
    logic         selectmem;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_ack;
    logic         stall;
    logic [W-1:0] wb_data;
    logic [3:0]   wb_rd;
    logic         wb_rwrite;
    logic [31:0]  wb_inst;
    logic         err;

    int n_checks = 0;
    int n_fails  = 0;

    mem_stage #(.WIDTH(W), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALURESULT (alu_result),
        .DATA2     (data2),
        .INST      (inst),
        .RD        (rd),
        .RWRITE    (rwrite),
        .WE        (we),
        .SELECTMEM (selectmem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .WB_DATA   (wb_data),
        .WB_RD     (wb_rd),
        .WB_RWRITE (wb_rwrite),
        .WB_INST   (wb_inst),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] a, input logic [31:0] d, input logic [31:0] i,
                          input logic [3:0] r, input logic rw, input logic w, input logic s);
        alu_result = a;
        data2      = d;
        inst       = i;
        rd         = r;
        rwrite     = rw;
        we         = w;
        selectmem  = s;
    endtask

    initial begin
        reset     = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        set_ex(32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // reset state
        #12;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rwrite", 32'(wb_rwrite), 32'h0);
        reset = 1'b1;
        tick();

        // ALU op passes through in one cycle
        set_ex(32'h0000_1234, 32'h0, 32'h0000_0033, 4'd3, 1'b1, 1'b0, 1'b0);
        #1;
        check("alu_stall", 32'(stall), 32'h0);
        check("alu_mem_req", 32'(mem_req), 32'h0);
        tick();
        check("alu_wb_data", wb_data, 32'h0000_1234);
        check("alu_wb_rd", 32'(wb_rd), 32'h3);
        check("alu_wb_rwrite", 32'(wb_rwrite), 32'h1);
        check("alu_wb_inst", wb_inst, 32'h0000_0033);

        // load, ack in the second ACCESS cycle
        set_ex(32'h0000_0100, 32'h0, 32'h0000_0003, 4'd5, 1'b1, 1'b0, 1'b1);
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_idle_stall", 32'(stall), 32'h1);
        check("ld_idle_req", 32'(mem_req), 32'h0);
        tick();
        check("ld_acc1_req", 32'(mem_req), 32'h1);
        check("ld_acc1_stall", 32'(stall), 32'h1);
        check("ld_acc1_addr", mem_addr, 32'h0000_0100);
        check("ld_acc1_we", 32'(mem_we), 32'h0);
        check("ld_acc1_wb_rwrite", 32'(wb_rwrite), 32'h0);
        check("ld_acc1_wb_data", wb_data, 32'h0);
        check("ld_acc1_wb_inst", wb_inst, 32'h0);
        tick();
        check("ld_acc2_req", 32'(mem_req), 32'h1);
        check("ld_acc2_stall", 32'(stall), 32'h1);
        check("ld_acc2_addr", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ld_done_stall", 32'(stall), 32'h0);
        check("ld_done_req", 32'(mem_req), 32'h0);
        check("ld_done_wb_rwrite", 32'(wb_rwrite), 32'h0);
        tick();
        check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        check("ld_wb_rd", 32'(wb_rd), 32'h5);
        check("ld_wb_rwrite", 32'(wb_rwrite), 32'h1);
        check("ld_wb_inst", wb_inst, 32'h0000_0003);

        // back-to-back ALU op right after the load
        set_ex(32'h0000_0077, 32'h0, 32'h0000_0013, 4'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("b2b_stall", 32'(stall), 32'h0);
        tick();
        check("b2b_wb_data", wb_data, 32'h0000_0077);
        check("b2b_wb_rd", 32'(wb_rd), 32'h7);
        check("b2b_wb_inst", wb_inst, 32'h0000_0013);

        // store, ack in the first ACCESS cycle; read data must be ignored
        set_ex(32'h0000_0200, 32'hA5A5_A5A5, 32'h0000_0023, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("st_idle_stall", 32'(stall), 32'h1);
        tick();
        check("st_req", 32'(mem_req), 32'h1);
        check("st_we", 32'(mem_we), 32'h1);
        check("st_addr", mem_addr, 32'h0000_0200);
        check("st_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check("st_done_stall", 32'(stall), 32'h0);
        check("st_done_req", 32'(mem_req), 32'h0);
        tick();
        check("st_wb_data", wb_data, 32'h0000_0200);
        check("st_wb_rwrite", 32'(wb_rwrite), 32'h0);

        // upstream bubble writes a zero bubble
        set_ex(32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bub_wb_data", wb_data, 32'h0);
        check("bub_wb_inst", wb_inst, 32'h0);

        // WE and SELECTMEM together behave as a store
        set_ex(32'h0000_0300, 32'h0000_0055, 32'h0000_0023, 4'd2, 1'b1, 1'b1, 1'b1);
        tick();
        check("both_we", 32'(mem_we), 32'h1);
        check("both_wdata", mem_wdata, 32'h0000_0055);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        tick();
        check("both_wb_data", wb_data, 32'h0000_0300);
        check("both_wb_rd", 32'(wb_rd), 32'h2);
        check("both_wb_rwrite", 32'(wb_rwrite), 32'h1);

        // timeout: load with no ack holds the request for exactly 4 cycles
        set_ex(32'h0000_0400, 32'h0, 32'h0000_0003, 4'd6, 1'b1, 1'b0, 1'b1);
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("to_idle_stall", 32'(stall), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_req_c%0d", i), 32'(mem_req), 32'h1);
            check($sformatf("to_err_c%0d", i), 32'(err), 32'h0);
        end
        tick();
        check("to_done_req", 32'(mem_req), 32'h0);
        check("to_done_stall", 32'(stall), 32'h0);
        check("to_done_err", 32'(err), 32'h1);
        tick();
        check("to_wb_rwrite", 32'(wb_rwrite), 32'h0);
        check("to_wb_data", wb_data, 32'h0);
        check("to_wb_rd", 32'(wb_rd), 32'h6);
        check("to_err_hold", 32'(err), 32'h1);
        set_ex(32'h0000_0ABC, 32'h0, 32'h0000_0033, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check("to_next_wb_data", wb_data, 32'h0000_0ABC);
        check("to_next_wb_rwrite", 32'(wb_rwrite), 32'h1);
        check("to_next_err", 32'(err), 32'h1);

        // reset asserted mid-ACCESS; EX/MEM still presents the load
        set_ex(32'h0000_0500, 32'h0, 32'h0000_0003, 4'd4, 1'b1, 1'b0, 1'b1);
        tick();
        check("mr_req_before", 32'(mem_req), 32'h1);
        reset = 1'b0;
        #1;
        check("mr_req", 32'(mem_req), 32'h0);
        check("mr_stall", 32'(stall), 32'h0);
        check("mr_err", 32'(err), 32'h0);
        check("mr_wb_data", wb_data, 32'h0);
        check("mr_wb_rd", 32'(wb_rd), 32'h0);
        check("mr_wb_rwrite", 32'(wb_rwrite), 32'h0);
        check("mr_wb_inst", wb_inst, 32'h0);
        set_ex(32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        tick();

        // stray ack in IDLE is ignored; ALU op passes normally
        set_ex(32'h0000_0042, 32'h0, 32'h0000_0033, 4'd2, 1'b1, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        #1;
        check("stray_req", 32'(mem_req), 32'h0);
        check("stray_stall", 32'(stall), 32'h0);
        tick();
        mem_ack = 1'b0;
        check("stray_wb_data", wb_data, 32'h0000_0042);
        check("stray_wb_rd", 32'(wb_rd), 32'h2);
        check("stray_req_after", 32'(mem_req), 32'h0);
        check("stray_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
